pe_array_drain: RTL and testbench

- Read-side counterpart of the systolic PE array: captures the array's ROWS x COLS accumulator outputs once all are valid, then streams them out one row per beat over a valid/ready interface to the output buffer or DMA.
- After capture, pulses a clear request back to the array so it can start the next tile while the snapshot drains.

---
 rtl/pe_array_drain_if.sv | 18 +
 rtl/pe_array_drain.sv | 129 ++++++++++++
 tb/tb_pe_array_drain.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_drain_if.sv
// Purpose: output beat bus of pe_array_drain (one PE-array row per beat).
// Latency: n/a (wires only).
// Backpressure: valid/ready; the master holds m_data/m_row/m_last while m_valid && !m_ready.
// Signals: m_valid, m_ready, m_data (COLS words, col 0 in MSB lane), m_row, m_last.
interface pe_array_drain_if #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int ACC_WIDTH = 32
);
  logic                      m_valid;
  logic                      m_ready;
  logic [COLS*ACC_WIDTH-1:0] m_data;
  logic [$clog2(ROWS)-1:0]   m_row;
  logic                      m_last;

  modport master (output m_valid, m_data, m_row, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_row, m_last, output m_ready);
endinterface

// File: rtl/pe_array_drain.sv
// Purpose: snapshot the PE array's ROWS x COLS accumulators once all valid, stream one row per beat.
// Latency: first beat 1 cycle after the capture edge; 1 row/cycle sustained, no bubbles.
// Backpressure: beat held stable while m_valid && !m_ready; start ignored while busy.
// Ports: clk, rst (sync, active-high), start, acc_in/acc_valid_in (row 0 col 0 in MSBs),
//        clear_acc_out (1-cycle pulse after capture), busy, done (1-cycle pulse after last beat),
//        m (pe_array_drain_if master: m_valid/m_ready/m_data/m_row/m_last).
// Option: define PE_DRAIN_RELU_EN to clamp negative words to 0 on the output path.
module pe_array_drain #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_in,
  input  logic [ROWS*COLS-1:0]           acc_valid_in,
  output logic                           clear_acc_out,
  output logic                           busy,
  output logic                           done,
  pe_array_drain_if.master               m
);

  localparam int RW    = $clog2(ROWS);
  localparam int ROW_W = COLS*ACC_WIDTH;
  localparam int TOT_W = ROWS*ROW_W;

  typedef enum logic [1:0] {IDLE, WAIT_VALID, STREAM} state_t;

  state_t            state_q, state_d;
  logic [TOT_W-1:0]  snap_q;
  logic [RW-1:0]     row_q;
  logic              clear_q;
  logic              done_q;
  logic              all_vld;
  logic              capture;
  logic              beat_hs;
  logic              last_beat;
  logic [ROW_W-1:0]  row_dat;
  logic [ROW_W-1:0]  row_out;

  assign all_vld   = &acc_valid_in;
  assign last_beat = (row_q == RW'(ROWS-1));
  assign beat_hs   = (state_q == STREAM) && m.m_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; capture marks the edge on which the snapshot is taken
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (all_vld) begin
            capture = 1'b1;
            state_d = STREAM;
          end else begin
            state_d = WAIT_VALID;
          end
        end
      end
      WAIT_VALID: begin
        if (all_vld) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (beat_hs && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row counter and one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clear_q <= capture;
      done_q  <= beat_hs && last_beat;
      if (beat_hs) row_q <= last_beat ? '0 : row_q + RW'(1);
    end
  end

  // Snapshot contents are don't-care after reset, so no reset term
  always_ff @(posedge clk) begin
    if (capture) snap_q <= acc_in;
  end

  // Row select: row r lives at word offset (ROWS-1-r)*COLS, so row 0 is in the MSBs
  always_comb begin
    row_dat = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == RW'(r)) row_dat = snap_q[(ROWS-1-r)*ROW_W +: ROW_W];
    end
  end

`ifdef PE_DRAIN_RELU_EN
  // Clamp on the read path only; the snapshot keeps raw values
  always_comb begin
    row_out = row_dat;
    for (int c = 0; c < COLS; c++) begin
      if (row_dat[c*ACC_WIDTH + ACC_WIDTH-1]) row_out[c*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
  end
`else
  assign row_out = row_dat;
`endif

  // Outputs; all derived from registered state, m_ready never reaches them directly
  always_comb begin
    busy          = (state_q != IDLE);
    m.m_valid     = (state_q == STREAM);
    m.m_last      = (state_q == STREAM) && last_beat;
    m.m_row       = row_q;
    m.m_data      = (state_q == STREAM) ? row_out : '0;
    clear_acc_out = clear_q;
    done          = done_q;
  end

endmodule

// File: tb/tb_pe_array_drain.sv
module tb_pe_array_drain;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int AW   = 32;
  localparam int DW   = COLS*AW;

`ifdef PE_DRAIN_RELU_EN
  localparam logic [AW-1:0] NEG5_EXP = 32'h0000_0000;
`else
  localparam logic [AW-1:0] NEG5_EXP = 32'hFFFF_FFFB;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic [ROWS*COLS*AW-1:0]   acc_in = '0;
  logic [ROWS*COLS-1:0]      acc_valid_in = '1;
  logic                      clear_acc_out, busy, done;

  pe_array_drain_if #(.ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(AW)) m_if ();

  pe_array_drain #(.ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .acc_in        (acc_in),
    .acc_valid_in  (acc_valid_in),
    .clear_acc_out (clear_acc_out),
    .busy          (busy),
    .done          (done),
    .m             (m_if.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference word table and scoreboard
  logic [AW-1:0] wv [ROWS][COLS];
  typedef struct {
    logic [DW-1:0] dat;
    int            row;
    logic          last;
  } beat_t;
  beat_t sb[$];

  task automatic set_pat(input int base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wv[r][c] = AW'(base + r*16 + c);
  endtask

  function automatic logic [ROWS*COLS*AW-1:0] pack_acc();
    logic [ROWS*COLS*AW-1:0] a;
    a = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        a[((ROWS-1-r)*COLS + (COLS-1-c))*AW +: AW] = wv[r][c];
    return a;
  endfunction

  function automatic logic [DW-1:0] exp_row(input int r);
    logic [DW-1:0] e;
    logic [AW-1:0] w;
    e = '0;
    for (int c = 0; c < COLS; c++) begin
      w = wv[r][c];
`ifdef PE_DRAIN_RELU_EN
      if (w[AW-1]) w = '0;
`endif
      e[(COLS-1-c)*AW +: AW] = w;
    end
    return e;
  endfunction

  task automatic push_exp();
    beat_t b;
    for (int r = 0; r < ROWS; r++) begin
      b.dat  = exp_row(r);
      b.row  = r;
      b.last = (r == ROWS-1);
      sb.push_back(b);
    end
  endtask

  // m_ready driver: always ready, or a repeating 1,0,0,1 pattern
  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  int         bp_idx  = 0;
  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_if.m_ready = bp_pat[bp_idx];
        bp_idx = (bp_idx + 1) % 4;
      end else begin
        m_if.m_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, done timing, clear pulse count
  logic          exp_done   = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] dat_prev   = '0;
  logic [1:0]    row_prev   = '0;
  int            clr_cnt    = 0;
  always @(negedge clk) begin
    beat_t b;
    chk("done_timing", done, exp_done);
    if (clear_acc_out) clr_cnt++;
    if (stall_prev) begin
      chk("stall_valid", m_if.m_valid, 1'b1);
      chk("stall_data", m_if.m_data, dat_prev);
      chk("stall_row", m_if.m_row, row_prev);
    end
    if (m_if.m_valid && m_if.m_ready && !rst) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", m_if.m_row, 'x);
      end else begin
        b = sb.pop_front();
        chk("beat_data", m_if.m_data, b.dat);
        chk("beat_row", m_if.m_row, b.row);
        chk("beat_last", m_if.m_last, b.last);
      end
    end
    exp_done   = m_if.m_valid && m_if.m_ready && m_if.m_last && !rst;
    stall_prev = m_if.m_valid && !m_if.m_ready && !rst;
    dat_prev   = m_if.m_data;
    row_prev   = m_if.m_row;
  end

  // Drive acc_in from the table, queue expected beats, one-cycle start pulse.
  // Returns at posedge+1 of the capture edge when all valid bits are set.
  task automatic start_drain();
    acc_in = pack_acc();
    push_exp();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns at posedge+1 of the cycle in which done is high (bounded)
  task automatic wait_done(input string tag);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (!done && i < 200);
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int c0;
    int k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_if.m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_clear", clear_acc_out, 1'b0);
    chk("rst_m_last", m_if.m_last, 1'b0);
    chk("rst_m_row", m_if.m_row, 0);
    chk("rst_m_data", m_if.m_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic drain: word (r,c) = r*16+c
    set_pat(0);
    c0 = clr_cnt;
    start_drain();
    chk("basic_latency_m_valid", m_if.m_valid, 1'b1);
    chk("basic_busy", busy, 1'b1);
    chk("basic_clear_pulse", clear_acc_out, 1'b1);
    chk("basic_beat0_row", m_if.m_row, 0);
    chk("basic_beat0_msb_lane", m_if.m_data[DW-1 -: AW], 0);
    chk("basic_beat0_lsb_lane", m_if.m_data[AW-1:0], 3);
    @(posedge clk);
    #1;
    chk("basic_clear_low", clear_acc_out, 1'b0);
    wait_done("basic_done");
    chk("basic_clear_count", clr_cnt - c0, 1);

    // Start in the done cycle is accepted
    set_pat(32'h40);
    start_drain();
    chk("b2b_m_valid", m_if.m_valid, 1'b1);
    wait_done("b2b_done");
    @(posedge clk);
    #1;
    chk("b2b_idle", busy, 1'b0);

    // Valid gating: one PE not ready for 5 cycles
    set_pat(32'h80);
    acc_valid_in    = '1;
    acc_valid_in[0] = 1'b0;
    c0 = clr_cnt;
    start_drain();
    for (int i = 0; i < 5; i++) begin
      chk("gate_busy", busy, 1'b1);
      chk("gate_m_valid", m_if.m_valid, 1'b0);
      chk("gate_clear", clear_acc_out, 1'b0);
      @(posedge clk);
      #1;
    end
    acc_valid_in[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("gate_m_valid_after", m_if.m_valid, 1'b1);
    chk("gate_clear_after", clear_acc_out, 1'b1);
    wait_done("gate_done");
    chk("gate_clear_count", clr_cnt - c0, 1);

    // Backpressure, plus a start while busy that must be ignored
    set_pat(32'hC0);
    bp_mode = 1'b1;
    start_drain();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("bp_done");
    bp_mode = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_no_restart_busy", busy, 1'b0);
      chk("bp_no_restart_valid", m_if.m_valid, 1'b0);
    end

    // Snapshot isolation: acc_in overwritten right after capture
    set_pat(32'h100);
    start_drain();
    acc_in = {(ROWS*COLS){32'hDEAD_BEEF}};
    wait_done("iso_done");

    // Reset in the middle of beat 2
    set_pat(32'h200);
    start_drain();
    k = 0;
    while (m_if.m_row != 2 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("mid_rst_reach_row2", m_if.m_row, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_m_valid", m_if.m_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_clear", clear_acc_out, 1'b0);
    rst = 1'b0;
    sb.delete();
    set_pat(32'h300);
    start_drain();
    chk("post_rst_row0", m_if.m_row, 0);
    wait_done("post_rst_done");

    // Signed words: clamp only when the option is built in
    set_pat(0);
    wv[0][0] = 32'hFFFF_FFFB;
    wv[0][1] = 32'd7;
    wv[3][3] = 32'h8000_0000;
    start_drain();
    chk("sign_neg5", m_if.m_data[DW-1 -: AW], NEG5_EXP);
    chk("sign_pos7", m_if.m_data[DW-AW-1 -: AW], 7);
    wait_done("sign_done");

    @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
